bcd_seq: RTL and testbench

- Sequential, parametrised binary-to-BCD converter using iterative double-dabble (shift-and-add-3).
- Processes one input bit per clock and replaces the combinational 12-bit/3-digit converter in wide datapaths (iteration counters, coordinate readouts) where the unrolled adder chain limits timing.
- Feeds the seven-segment and text-overlay display drivers.
- Uses a valid/ready handshake on both the input and output sides.

---
 rtl/bcd_pkg.sv | 36 +++
 rtl/bcd_seq_if.sv | 31 +++
 rtl/bcd_digit_adj.sv | 15 +
 rtl/bcd_seq.sv | 137 +++++++++++++
 tb/tb_bcd_seq.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Purpose : shared types and constants for the sequential binary-to-BCD converter.
// Latency : n/a (declarations only).
// Backpressure : n/a.
// Contents: bcd_digit_t, bcd_state_t {IDLE, SHIFT, DONE}, add-3 constants,
//           bcd_digits_for() giving the minimum digit count for a binary width.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
  localparam bcd_digit_t BCD_ADJ_ADD    = 4'd3;

  // Smallest digit count d with 10^d > 2^width - 1.
  function automatic int bcd_digits_for(input int width);
    longint max_v;
    longint lim;
    int     d;
    max_v = (longint'(1) << width) - 1;
    lim   = 10;
    d     = 1;
    for (int i = 0; i < 20; i++) begin
      if (lim <= max_v) begin
        lim = lim * 10;
        d   = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_seq_if.sv
// Purpose : handshake/data bundle between a producer/consumer and bcd_seq.
// Latency : n/a (wires only).
// Backpressure : in_valid/in_ready on the input side, out_valid/out_ready on the result side.
// Signals : in_valid, in_ready, binary[BIN_W], out_valid, out_ready, bcd[4*DIGITS], overflow,
//           blank[DIGITS] only when BCD_SEQ_BLANK_EN is defined.
// Modports: master = producer/consumer side, slave = converter side.
interface bcd_seq_if #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      binary;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;
`ifdef BCD_SEQ_BLANK_EN
  logic [DIGITS-1:0]     blank;

  modport master (output in_valid, binary, out_ready,
                  input  in_ready, out_valid, bcd, overflow, blank);
  modport slave  (input  in_valid, binary, out_ready,
                  output in_ready, out_valid, bcd, overflow, blank);
`else
  modport master (output in_valid, binary, out_ready,
                  input  in_ready, out_valid, bcd, overflow);
  modport slave  (input  in_valid, binary, out_ready,
                  output in_ready, out_valid, bcd, overflow);
`endif
endinterface

// File: rtl/bcd_digit_adj.sv
// Purpose : double-dabble digit correction, adds 3 to a BCD digit that is >= 5.
// Latency : combinational.
// Backpressure : none.
// Ports   : d_i digit before shift, d_o corrected digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  bcd_digit_t d_i,
  output bcd_digit_t d_o
);

  // d_i never exceeds 9 in a well-formed accumulator, so the 4-bit sum cannot wrap.
  assign d_o = (d_i >= BCD_ADJ_THRESH) ? bcd_digit_t'(d_i + BCD_ADJ_ADD) : d_i;

endmodule

// File: rtl/bcd_seq.sv
// Purpose : iterative binary-to-BCD converter (double dabble), one input bit per clock.
// Latency : out_valid rises BIN_W cycles after the accept edge; one conversion per BIN_W+2 cycles.
// Backpressure : result held in DONE until out_ready; in_ready low outside IDLE, no input buffering.
// Ports   : clk, reset (sync, active-high), bus (bcd_seq_if.slave).
// Option  : BCD_SEQ_BLANK_EN adds bus.blank, leading-zero flags registered with bcd.
module bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic      clk,
  input  logic      reset,
  bcd_seq_if.slave  bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);

  bcd_state_t          state_q,   state_d;
  logic [BIN_W-1:0]    shreg_q,   shreg_d;
  logic [BCD_W-1:0]    acc_q,     acc_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic                ovf_acc_q, ovf_acc_d;
  logic [BCD_W-1:0]    bcd_q,     bcd_d;
  logic                ovf_q,     ovf_d;

  logic [BCD_W-1:0]    acc_adj;
  logic [BCD_W-1:0]    acc_shift;
  logic                ovf_step;

  // Correct every digit, then shift the whole {digits, shreg} chain left by one.
  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (acc_q[4*k +: 4]),
      .d_o (acc_adj[4*k +: 4])
    );
  end

  assign acc_shift = {acc_adj[BCD_W-2:0], shreg_q[BIN_W-1]};
  // The bit shifted out of the top digit is lost precision: value exceeds 10^DIGITS-1.
  assign ovf_step  = acc_adj[BCD_W-1];

`ifdef BCD_SEQ_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d, blank_nxt;
  logic              zero_run;

  // blank[k] is set while digit k and all higher digits are zero; digit 0 always shows.
  always_comb begin
    blank_nxt = '0;
    zero_run  = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run     = zero_run & (acc_shift[4*k +: 4] == 4'd0);
      blank_nxt[k] = zero_run;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
`ifdef BCD_SEQ_BLANK_EN
    blank_d   = blank_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          shreg_d   = bus.binary;
          acc_d     = '0;
          ovf_acc_d = 1'b0;
          cnt_d     = CNT_W'(BIN_W - 1);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d   = {shreg_q[BIN_W-2:0], 1'b0};
        acc_d     = acc_shift;
        ovf_acc_d = ovf_acc_q | ovf_step;
        if (cnt_q == '0) begin
          // Last bit: publish the result register on the way into DONE.
          state_d = DONE;
          bcd_d   = acc_shift;
          ovf_d   = ovf_acc_q | ovf_step;
`ifdef BCD_SEQ_BLANK_EN
          blank_d = blank_nxt;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
`ifdef BCD_SEQ_BLANK_EN
      blank_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
`ifdef BCD_SEQ_BLANK_EN
      blank_q   <= blank_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.bcd       = bcd_q;
  assign bus.overflow  = ovf_q;
`ifdef BCD_SEQ_BLANK_EN
  assign bus.blank     = blank_q;
`endif

endmodule

// File: tb/tb_bcd_seq.sv
// Bench for bcd_seq: three instances (12b/4 digits, 12b/3 digits, 16b/5 digits)
// checked against a decimal reference computed with plain division.
// Build with BCD_SEQ_BLANK_EN defined to also check the leading-zero flags.
module tb_bcd_seq;
  import bcd_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  bcd_seq_if #(.BIN_W(12), .DIGITS(4)) if0 ();
  bcd_seq_if #(.BIN_W(12), .DIGITS(3)) if1 ();
  bcd_seq_if #(.BIN_W(16), .DIGITS(5)) if2 ();

  bcd_seq #(.BIN_W(12), .DIGITS(4)) u0 (.clk(clk), .reset(reset), .bus(if0));
  bcd_seq #(.BIN_W(12), .DIGITS(3)) u1 (.clk(clk), .reset(reset), .bus(if1));
  bcd_seq #(.BIN_W(16), .DIGITS(5)) u2 (.clk(clk), .reset(reset), .bus(if2));

  // ---------------- reference model ----------------
  function automatic longint pow10(input int d);
    longint p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  // Low d decimal digits of v, packed 4 bits per digit.
  function automatic logic [31:0] ref_bcd(input longint v, input int d);
    logic [31:0] o = '0;
    longint      r = v;
    for (int k = 0; k < d; k++) begin
      o[4*k +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return o;
  endfunction

  function automatic logic ref_ovf(input longint v, input int d);
    return (v >= pow10(d));
  endfunction

  function automatic logic [7:0] ref_blank(input longint v, input int d);
    logic [7:0] b = '0;
    longint     m = v % pow10(d);
    for (int k = 1; k < d; k++) b[k] = (m < pow10(k));
    return b;
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic conv0(input logic [11:0] v, output int lat);
    if0.binary = v; if0.in_valid = 1'b1; if0.out_ready = 1'b1;
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
    lat = 0;
    while (if0.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    @(posedge clk); #1;
  endtask

  task automatic conv1(input logic [11:0] v, output int lat);
    if1.binary = v; if1.in_valid = 1'b1; if1.out_ready = 1'b1;
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
    lat = 0;
    while (if1.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    if0.in_valid = 0; if0.out_ready = 0; if0.binary = '0;
    if1.in_valid = 0; if1.out_ready = 0; if1.binary = '0;
    if2.in_valid = 0; if2.out_ready = 0; if2.binary = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (if0.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", if0.in_ready); end
    n_chk++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", if0.out_valid); end
    n_chk++; if (if0.bcd !== 16'h0) begin n_fail++; $display("FAIL reset_bcd: got %h want 0000", if0.bcd); end
    n_chk++; if (if0.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", if0.overflow); end
    n_chk++; if (if1.in_ready !== 1'b1 || if2.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_others: got %b%b want 11", if1.in_ready, if2.in_ready); end
`ifdef BCD_SEQ_BLANK_EN
    n_chk++; if (if0.blank !== 4'b0) begin n_fail++; $display("FAIL reset_blank: got %b want 0000", if0.blank); end
`endif
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_max;
    int lat;
    logic exp_ovf;
    conv0(12'd4095, lat);
    exp_ovf = (4 < bcd_digits_for(12));
    n_chk++; if (lat != 12) begin n_fail++; $display("FAIL max_latency: got %0d want 12", lat); end
    n_chk++; if (if0.bcd !== 16'h4095) begin n_fail++; $display("FAIL max_bcd: got %h want 4095", if0.bcd); end
    n_chk++; if (if0.overflow !== exp_ovf) begin n_fail++; $display("FAIL max_overflow: got %b want %b", if0.overflow, exp_ovf); end
  endtask

  task automatic test_zero;
    int lat;
    conv0(12'd0, lat);
    n_chk++; if (if0.bcd !== 16'h0000) begin n_fail++; $display("FAIL zero_bcd: got %h want 0000", if0.bcd); end
    n_chk++; if (if0.overflow !== 1'b0) begin n_fail++; $display("FAIL zero_overflow: got %b want 0", if0.overflow); end
`ifdef BCD_SEQ_BLANK_EN
    n_chk++; if (if0.blank !== 4'b1110) begin n_fail++; $display("FAIL zero_blank: got %b want 1110", if0.blank); end
`endif
  endtask

  task automatic test_random;
    int          lat;
    logic [11:0] v;
    logic [31:0] eb;
    logic [7:0]  bl;
    for (int i = 0; i < 25; i++) begin
      v  = 12'($urandom_range(0, 4095));
      conv0(v, lat);
      eb = ref_bcd(v, 4);
      bl = ref_blank(v, 4);
      n_chk++; if (lat != 12) begin n_fail++; $display("FAIL rand_latency v=%0d: got %0d want 12", v, lat); end
      n_chk++; if (if0.bcd !== eb[15:0]) begin n_fail++; $display("FAIL rand_bcd v=%0d: got %h want %h", v, if0.bcd, eb[15:0]); end
      n_chk++; if (if0.overflow !== ref_ovf(v, 4)) begin n_fail++; $display("FAIL rand_overflow v=%0d: got %b", v, if0.overflow); end
`ifdef BCD_SEQ_BLANK_EN
      n_chk++; if (if0.blank !== bl[3:0]) begin n_fail++; $display("FAIL rand_blank v=%0d: got %b want %b", v, if0.blank, bl[3:0]); end
`else
      if (bl[0] !== 1'b0) $display("note: blank model digit 0 set");
`endif
    end
  endtask

  task automatic test_backpressure;
    int w;
    if0.binary = 12'd123; if0.in_valid = 1'b1; if0.out_ready = 1'b0;
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
    w = 0;
    while (if0.out_valid !== 1'b1 && w < 100) begin
      @(posedge clk); #1; w++;
    end
    n_chk++; if (w != 12) begin n_fail++; $display("FAIL bp_latency: got %0d want 12", w); end
    for (int i = 0; i < 20; i++) begin
      if0.in_valid = (i % 2 == 1);
      if0.binary   = 12'd777;
      @(posedge clk); #1;
      n_chk++; if (if0.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid c%0d: got %b want 1", i, if0.out_valid); end
      n_chk++; if (if0.bcd !== 16'h0123) begin n_fail++; $display("FAIL bp_bcd c%0d: got %h want 0123", i, if0.bcd); end
      n_chk++; if (if0.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c%0d: got %b want 0", i, if0.in_ready); end
    end
    if0.in_valid  = 1'b0;
    if0.out_ready = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (if0.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b want 1", if0.in_ready); end
    n_chk++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid: got %b want 0", if0.out_valid); end
    n_chk++; if (if0.bcd !== 16'h0123) begin n_fail++; $display("FAIL bp_release_bcd: got %h want 0123", if0.bcd); end
  endtask

  task automatic test_reset_mid;
    int lat;
    if0.binary = 12'd3000; if0.in_valid = 1'b1; if0.out_ready = 1'b1;
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (if0.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", if0.in_ready); end
    n_chk++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", if0.out_valid); end
    n_chk++; if (if0.bcd !== 16'h0) begin n_fail++; $display("FAIL midrst_bcd: got %h want 0000", if0.bcd); end
    reset = 1'b0;
    @(posedge clk); #1;
    conv0(12'd42, lat);
    n_chk++; if (lat != 12) begin n_fail++; $display("FAIL midrst_latency: got %0d want 12", lat); end
    n_chk++; if (if0.bcd !== 16'h0042) begin n_fail++; $display("FAIL midrst_bcd42: got %h want 0042", if0.bcd); end
  endtask

  task automatic test_digits3;
    int          lat;
    logic [11:0] v;
    logic [31:0] eb;
    conv1(12'd1000, lat);
    n_chk++; if (if1.bcd !== 12'h000) begin n_fail++; $display("FAIL d3_1000_bcd: got %h want 000", if1.bcd); end
    n_chk++; if (if1.overflow !== 1'b1) begin n_fail++; $display("FAIL d3_1000_overflow: got %b want 1", if1.overflow); end
    conv1(12'd999, lat);
    n_chk++; if (if1.bcd !== 12'h999) begin n_fail++; $display("FAIL d3_999_bcd: got %h want 999", if1.bcd); end
    n_chk++; if (if1.overflow !== 1'b0) begin n_fail++; $display("FAIL d3_999_overflow: got %b want 0", if1.overflow); end
    for (int i = 0; i < 10; i++) begin
      v  = 12'($urandom_range(0, 4095));
      conv1(v, lat);
      eb = ref_bcd(v, 3);
      n_chk++; if (lat != 12) begin n_fail++; $display("FAIL d3_rand_latency v=%0d: got %0d want 12", v, lat); end
      n_chk++; if (if1.bcd !== eb[11:0]) begin n_fail++; $display("FAIL d3_rand_bcd v=%0d: got %h want %h", v, if1.bcd, eb[11:0]); end
      n_chk++; if (if1.overflow !== ref_ovf(v, 3)) begin n_fail++; $display("FAIL d3_rand_overflow v=%0d: got %b", v, if1.overflow); end
    end
  endtask

  task automatic test_back_to_back;
    int          cyc;
    int          t[$];
    logic [19:0] r[$];
    if2.out_ready = 1'b1;
    if2.binary    = 16'hFFFF;
    if2.in_valid  = 1'b1;
    @(posedge clk); #1;
    // Captured value must not follow binary while converting.
    if2.binary = 16'd1;
    cyc = 0;
    while (t.size() < 2 && cyc < 80) begin
      @(posedge clk); #1; cyc++;
      if (if2.out_valid === 1'b1) begin
        t.push_back(cyc);
        r.push_back(if2.bcd);
        if (t.size() == 2) if2.in_valid = 1'b0;
      end
    end
    if2.in_valid = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (t.size() != 2) begin
      n_fail++; $display("FAIL b2b_results: got %0d results want 2", t.size());
    end else begin
      n_chk++; if (t[0] != 16) begin n_fail++; $display("FAIL b2b_latency: got %0d want 16", t[0]); end
      n_chk++; if (r[0] !== 20'h65535) begin n_fail++; $display("FAIL b2b_first_bcd: got %h want 65535", r[0]); end
      n_chk++; if (r[1] !== 20'h00001) begin n_fail++; $display("FAIL b2b_second_bcd: got %h want 00001", r[1]); end
      n_chk++; if (t[1] - t[0] != 18) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 18", t[1] - t[0]); end
    end
    n_chk++; if (if2.overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow: got %b want 0", if2.overflow); end
  endtask

  initial begin
    test_reset();
    test_max();
    test_zero();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_digits3();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
